// File: rtl/cpu_6502_pe_pkg.sv
// Shared widths, nibble-index type and the production coefficient set for the
// nibble-serial systolic FIR processing element.
package cpu_6502_pe_pkg;

  localparam int CW      = 6;   // coefficient width
  localparam int XW      = 8;   // sample width (2 nibbles)
  localparam int YW      = 16;  // partial-sum width (one frame)
  localparam int NIBBLES = 4;   // nibbles per frame
  localparam int NIB_W   = 4;   // bits per nibble

  typedef logic [1:0] nib_idx_t;

  // Production 8-tap coefficient set, tap 0 first.
  localparam logic [CW-1:0] DEFAULT_COEF [0:7] = '{
    6'd4, 6'd12, 6'd25, 6'd34, 6'd34, 6'd25, 6'd12, 6'd4
  };

endpackage

// File: rtl/cpu_6502_pe_shreg.sv
// Four-nibble parallel-load / serial-out register, LS nibble first.
// Ports:
//   clk, reset : clock and synchronous active-high clear
//   load       : parallel-load din (takes priority over shifting)
//   din        : frame word to serialise
//   dout       : current output nibble (register bits, no gating)
// Zeros shift in from the top, so the register drains to zero four cycles
// after a load and dout reads 0 whenever no frame is in flight.
module cpu_6502_pe_shreg
  import cpu_6502_pe_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [NIBBLES*NIB_W-1:0]   din,
  output logic [NIB_W-1:0]           dout
);

  logic [NIBBLES*NIB_W-1:0] sh_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_p1 <= '0;
    end else if (load) begin
      sh_p1 <= din;
    end else begin
      sh_p1 <= {{NIB_W{1'b0}}, sh_p1[NIBBLES*NIB_W-1:NIB_W]};
    end
  end

  assign dout = sh_p1[NIB_W-1:0];

endmodule

// File: rtl/cpu_6502_pe.sv
// Nibble-serial processing element for a systolic FIR chain.
// Accumulates a 4-nibble input frame (sample X in nibbles 0-1, partial sum Y in
// nibbles 0-3), computes Y + Cin*X mod 2^16 on the last nibble and streams the
// result out over the next four cycles together with the previous frame's X.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   Rdy        : input frame strobe, high for each input nibble
//   Cin        : unsigned tap coefficient, used on nibble 3
//   Xin, Yin   : sample / partial-sum nibbles, LS first
//   Vld        : output frame strobe
//   Xout, Yout : delayed-sample / result nibbles, LS first, 0 when Vld=0
module cpu_6502_pe
  import cpu_6502_pe_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             Rdy,
  input  logic [CW-1:0]    Cin,
  input  logic [NIB_W-1:0] Xin,
  input  logic [NIB_W-1:0] Yin,
  output logic             Vld,
  output logic [NIB_W-1:0] Xout,
  output logic [NIB_W-1:0] Yout
);

  function automatic logic [YW-1:0] mac_wrap(input logic [YW-1:0] y,
                                              input logic [CW-1:0] c,
                                              input logic [XW-1:0] x);
    logic [CW+XW-1:0] prod;
    prod = c * x;
    return y + YW'(prod);  // wraps silently
  endfunction

  nib_idx_t          cnt_p0;
  logic [XW-1:0]     x_acc_p0;
  logic [YW-5:0]     y_acc_p0;
  logic [XW-1:0]     xprev;
  logic              done_p0;
  logic [YW-1:0]     result_p0;
  logic              vld_p1;
  logic [1:0]        left_p1;

  // ---- stage p0: nibble capture and frame completion ----
  assign done_p0   = Rdy && (cnt_p0 == 2'd3);
  assign result_p0 = mac_wrap({Yin, y_acc_p0}, Cin, x_acc_p0);

  // Any cycle with Rdy low discards a partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0 <= '0;
      xprev  <= '0;
    end else if (Rdy) begin
      cnt_p0 <= cnt_p0 + 2'd1;
      if (done_p0) xprev <= x_acc_p0;
    end else begin
      cnt_p0 <= '0;
    end
  end

  // Accumulators are always rewritten before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (Rdy) begin
      case (cnt_p0)
        2'd0: begin
          x_acc_p0[3:0] <= Xin;
          y_acc_p0[3:0] <= Yin;
        end
        2'd1: begin
          x_acc_p0[7:4] <= Xin;
          y_acc_p0[7:4] <= Yin;
        end
        2'd2: y_acc_p0[11:8] <= Yin;
        default: ;
      endcase
    end
  end

  // ---- stage p1: serial output frame ----
  // A completion on the last output cycle reloads with no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      left_p1 <= '0;
    end else if (done_p0) begin
      vld_p1  <= 1'b1;
      left_p1 <= 2'd3;
    end else if (left_p1 != 2'd0) begin
      left_p1 <= left_p1 - 2'd1;
    end else begin
      vld_p1  <= 1'b0;
    end
  end

  // xprev still holds the previous frame's sample on the load edge.
  cpu_6502_pe_shreg u_y_sh (
    .clk   (clk),
    .reset (reset),
    .load  (done_p0),
    .din   (result_p0),
    .dout  (Yout)
  );

  cpu_6502_pe_shreg u_x_sh (
    .clk   (clk),
    .reset (reset),
    .load  (done_p0),
    .din   ({{(YW-XW){1'b0}}, xprev}),
    .dout  (Xout)
  );

  assign Vld = vld_p1;

endmodule

// File: tb/tb_cpu_6502_pe.sv
module tb_cpu_6502_pe;
  import cpu_6502_pe_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Rdy = 1'b0;
  logic [5:0] Cin = '0;
  logic [3:0] Xin = '0;
  logic [3:0] Yin = '0;
  logic       Vld;
  logic [3:0] Xout;
  logic [3:0] Yout;

  always #5 clk = ~clk;

  cpu_6502_pe dut (
    .clk(clk), .reset(reset), .Rdy(Rdy), .Cin(Cin), .Xin(Xin), .Yin(Yin),
    .Vld(Vld), .Xout(Xout), .Yout(Yout)
  );

  // 8-PE chain for the impulse test
  logic       c_rdy = 1'b0;
  logic [3:0] c_x = '0;
  logic       ch_vld [0:8];
  logic [3:0] ch_x   [0:8];
  logic [3:0] ch_y   [0:8];
  assign ch_vld[0] = c_rdy;
  assign ch_x[0]   = c_x;
  assign ch_y[0]   = 4'h0;

  for (genvar g = 0; g < 8; g++) begin : g_chain
    cpu_6502_pe u_pe (
      .clk(clk), .reset(reset), .Rdy(ch_vld[g]), .Cin(DEFAULT_COEF[g]),
      .Xin(ch_x[g]), .Yin(ch_y[g]),
      .Vld(ch_vld[g+1]), .Xout(ch_x[g+1]), .Yout(ch_y[g+1])
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output frame collector for the single DUT
  logic [15:0] yq[$];
  logic [15:0] xq[$];
  logic [15:0] ybuf = '0, xbuf = '0;
  int n = 0, run = 0, max_run = 0, first_vld = -1, vld_cnt = 0;

  always @(negedge clk) begin
    if (Vld) begin
      ybuf = {Yout, ybuf[15:4]};
      xbuf = {Xout, xbuf[15:4]};
      n++; run++; vld_cnt++;
      if (run > max_run) max_run = run;
      if (first_vld < 0) first_vld = cyc;
      if (n == 4) begin
        yq.push_back(ybuf);
        xq.push_back(xbuf);
        n = 0;
      end
    end else begin
      run = 0;
      n = 0;
    end
  end

  // Output frame collector for the chain tail
  logic [15:0] cq[$];
  logic [15:0] cbuf = '0;
  int cn = 0;
  always @(negedge clk) begin
    if (ch_vld[8]) begin
      cbuf = {ch_y[8], cbuf[15:4]};
      cn++;
      if (cn == 4) begin
        cq.push_back(cbuf);
        cn = 0;
      end
    end else begin
      cn = 0;
    end
  end

  int last_drive = 0;

  task automatic send(input logic [5:0] c, input logic [7:0] x, input logic [15:0] y);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      Rdy = 1'b1;
      Cin = c;
      Xin = (i == 0) ? x[3:0] : (i == 1) ? x[7:4] : 4'hA;  // nibbles 2-3 ignored
      Yin = y[i*4 +: 4];
    end
    last_drive = cyc;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      Rdy = 1'b0;
      Xin = '0;
      Yin = '0;
    end
  endtask

  task automatic wait_frames(input int k);
    for (int i = 0; i < 100 && yq.size() < k; i++) @(negedge clk);
    check_eq("frame_timeout", yq.size(), k);
  endtask

  task automatic clear_mon();
    yq.delete();
    xq.delete();
    max_run = 0;
    first_vld = -1;
    vld_cnt = 0;
  endtask

  int d1;
  logic [7:0] imp;

  initial begin
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_vld", Vld, 0);
    check_eq("rst_xout", Xout, 0);
    check_eq("rst_yout", Yout, 0);

    // back-to-back frames
    clear_mon();
    send(6'd4, 8'h12, 16'h0100);
    d1 = last_drive;
    send(6'd4, 8'h05, 16'h0000);
    idle(8);
    wait_frames(2);
    check_eq("f1_y", yq[0], 16'h0148);
    check_eq("f1_x", xq[0], 16'h0000);
    check_eq("f2_y", yq[1], 16'h0014);
    check_eq("f2_x", xq[1], 16'h0012);
    check_eq("latency", first_vld, d1 + 1);
    check_eq("b2b_run", max_run, 8);

    // modular wrap
    clear_mon();
    send(6'd63, 8'hFF, 16'hFFFF);
    idle(6);
    wait_frames(1);
    check_eq("wrap_y", yq[0], 16'h3EC0);
    check_eq("wrap_x", xq[0], 16'h0005);
    check_eq("wrap_run", max_run, 4);

    // aborted partial frame
    clear_mon();
    @(negedge clk); Rdy = 1'b1; Cin = 6'd12; Xin = 4'h7; Yin = 4'h7;
    @(negedge clk); Rdy = 1'b1;
    idle(8);
    check_eq("abort_vld", vld_cnt, 0);
    send(6'd12, 8'h01, 16'h0000);
    idle(6);
    wait_frames(1);
    check_eq("abort_next_y", yq[0], 16'h000C);
    check_eq("abort_next_x", xq[0], 16'h00FF);

    // reset during an output frame
    send(6'd4, 8'h12, 16'h0000);
    @(negedge clk); Rdy = 1'b0;
    check_eq("pre_rst_vld", Vld, 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_vld", Vld, 0);
    check_eq("mid_rst_xout", Xout, 0);
    check_eq("mid_rst_yout", Yout, 0);
    reset = 1'b0;
    idle(2);
    clear_mon();
    send(6'd4, 8'h05, 16'h0003);
    idle(6);
    wait_frames(1);
    check_eq("post_rst_y", yq[0], 16'h0017);
    check_eq("post_rst_x", xq[0], 16'h0000);

    // 8-PE chain, impulse over back-to-back frames
    cq.delete();
    for (int f = 0; f < 10; f++) begin
      imp = (f == 0) ? 8'h01 : 8'h00;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        c_rdy = 1'b1;
        c_x = (i == 0) ? imp[3:0] : (i == 1) ? imp[7:4] : 4'h0;
      end
    end
    @(negedge clk); c_rdy = 1'b0; c_x = '0;
    for (int i = 0; i < 200 && cq.size() < 10; i++) @(negedge clk);
    check_eq("chain_timeout", cq.size(), 10);
    check_eq("chain_0", cq[0], 4);
    check_eq("chain_1", cq[1], 12);
    check_eq("chain_2", cq[2], 25);
    check_eq("chain_3", cq[3], 34);
    check_eq("chain_4", cq[4], 34);
    check_eq("chain_5", cq[5], 25);
    check_eq("chain_6", cq[6], 12);
    check_eq("chain_7", cq[7], 4);
    check_eq("chain_8", cq[8], 0);
    check_eq("chain_9", cq[9], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
